// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned c_pc_width    = 6;
    localparam int unsigned c_instr_width = 16;
    localparam logic [15:0] c_nop         = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register. Flush beats load, load beats hold.
//               When neither loaded nor held the entry becomes a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = c_pc_width,
    parameter int unsigned INSTR_WIDTH = c_instr_width
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   hold,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] d_instr,
    input  logic [PC_WIDTH-1:0]    d_pc,
    input  logic [PC_WIDTH-1:0]    d_pc_plus1,
    output logic                   q_valid,
    output logic [INSTR_WIDTH-1:0] q_instr,
    output logic [PC_WIDTH-1:0]    q_pc,
    output logic [PC_WIDTH-1:0]    q_pc_plus1
);

    // Entry update: flush invalidates, load captures, hold keeps, else bubble
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_valid    <= 1'b0;
            q_instr    <= INSTR_WIDTH'(c_nop);
            q_pc       <= '0;
            q_pc_plus1 <= '0;
        end else if (flush) begin
            q_valid    <= 1'b0;
        end else if (load) begin
            q_valid    <= 1'b1;
            q_instr    <= d_instr;
            q_pc       <= d_pc;
            q_pc_plus1 <= d_pc_plus1;
        end else if (!hold) begin
            // Decode consumed the entry and nothing new arrived
            q_valid    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch control. Computes the next PC, issues the
//               instruction-memory request and loads the IF/ID register,
//               handling decode stalls, redirects and variable memory latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = c_pc_width,
    parameter int unsigned         INSTR_WIDTH = c_instr_width,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [PC_WIDTH-1:0]    pc_cur,
    output logic [PC_WIDTH-1:0]    pc_next,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic                   ifid_valid,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [PC_WIDTH-1:0]    ifid_pc_plus1
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [INSTR_WIDTH-1:0] r_hold_instr;
    logic [PC_WIDTH-1:0]    r_hold_pc;
    logic [PC_WIDTH-1:0]    r_drain_addr;

    logic [PC_WIDTH-1:0]    w_pc_inc;
    logic [PC_WIDTH-1:0]    w_hold_pc_inc;

    logic                   w_if_load;
    logic                   w_if_hold;
    logic                   w_if_flush;
    logic [INSTR_WIDTH-1:0] w_if_instr;
    logic [PC_WIDTH-1:0]    w_if_pc;
    logic [PC_WIDTH-1:0]    w_if_pc_plus1;

    logic                   w_hold_capture;
    logic                   w_hold_clear;
    logic                   w_drain_capture;

    // Increments wrap naturally at the PC width
    assign w_pc_inc      = pc_cur + PC_WIDTH'(1);
    assign w_hold_pc_inc = r_hold_pc + PC_WIDTH'(1);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, next PC, memory request and IF/ID control
    always_comb begin
        w_state_next    = r_state;
        pc_next         = pc_cur;
        imem_req        = 1'b0;
        imem_addr       = pc_cur;
        w_if_load       = 1'b0;
        w_if_hold       = 1'b0;
        w_if_flush      = 1'b0;
        w_if_instr      = imem_rdata;
        w_if_pc         = pc_cur;
        w_if_pc_plus1   = w_pc_inc;
        w_hold_capture  = 1'b0;
        w_hold_clear    = 1'b0;
        w_drain_capture = 1'b0;

        case (r_state)
            BOOT: begin
                // Redirects are ignored until the first fetch is issued
                pc_next      = RESET_PC;
                w_state_next = FETCH;
            end

            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_cur;
                if (redirect_valid) begin
                    pc_next      = redirect_target;
                    w_if_flush   = 1'b1;
                    w_hold_clear = 1'b1;
                    if (!imem_ready) begin
                        // Outstanding request must complete at its own address
                        w_drain_capture = 1'b1;
                        w_state_next    = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_next = w_pc_inc;
                    if (stall) begin
                        w_hold_capture = 1'b1;
                        w_if_hold      = 1'b1;
                        w_state_next   = HOLD;
                    end else begin
                        w_if_load = 1'b1;
                    end
                end else begin
                    // Keep the address steady while waiting on memory
                    pc_next   = pc_cur;
                    w_if_hold = stall;
                end
            end

            HOLD: begin
                pc_next = pc_cur;
                if (redirect_valid) begin
                    pc_next      = redirect_target;
                    w_if_flush   = 1'b1;
                    w_hold_clear = 1'b1;
                    w_state_next = FETCH;
                end else if (!stall) begin
                    w_if_load     = 1'b1;
                    w_if_instr    = r_hold_instr;
                    w_if_pc       = r_hold_pc;
                    w_if_pc_plus1 = w_hold_pc_inc;
                    w_state_next  = FETCH;
                end else begin
                    w_if_hold = 1'b1;
                end
            end

            DRAIN: begin
                // Finish the abandoned request; its data is thrown away
                imem_req  = 1'b1;
                imem_addr = r_drain_addr;
                pc_next   = pc_cur;
                if (redirect_valid) begin
                    pc_next      = redirect_target;
                    w_if_flush   = 1'b1;
                    w_hold_clear = 1'b1;
                end else begin
                    w_if_hold = stall;
                    if (imem_ready) begin
                        w_state_next = FETCH;
                    end
                end
            end

            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // Hold buffer: parks a fetched instruction while decode is stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_instr <= INSTR_WIDTH'(c_nop);
            r_hold_pc    <= '0;
        end else if (w_hold_clear) begin
            r_hold_instr <= INSTR_WIDTH'(c_nop);
            r_hold_pc    <= '0;
        end else if (w_hold_capture) begin
            r_hold_instr <= imem_rdata;
            r_hold_pc    <= pc_cur;
        end
    end

    // Drain address: the address of the request abandoned by a redirect
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drain_addr <= '0;
        end else if (w_drain_capture) begin
            r_drain_addr <= pc_cur;
        end
    end

    ifid_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ifid_reg (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (w_if_load),
        .hold       (w_if_hold),
        .flush      (w_if_flush),
        .d_instr    (w_if_instr),
        .d_pc       (w_if_pc),
        .d_pc_plus1 (w_if_pc_plus1),
        .q_valid    (ifid_valid),
        .q_instr    (ifid_instr),
        .q_pc       (ifid_pc),
        .q_pc_plus1 (ifid_pc_plus1)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios plus a
//               randomized run against a program-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  pc;
    logic [5:0]  pc_next;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_target = 6'd0;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [5:0]  ifid_pc;
    logic [5:0]  ifid_pc_plus1;

    logic [15:0] mem [64];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    // The PC register the stage feeds
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc <= 6'd0;
        else          pc <= pc_next;
    end

    fetch_stage dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pc_cur          (pc),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus1   (ifid_pc_plus1)
    );

    // One cycle: drive controls after the falling edge, then answer the
    // memory request; returns with everything settled before the next rise.
    task automatic drive(input logic st, input logic rv, input logic [5:0] rt, input logic rdy);
        @(negedge clock);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        #1;
        imem_ready = rdy & imem_req;
        imem_rdata = imem_ready ? mem[imem_addr] : 16'($urandom);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        n_checks++; if (pc_next !== 6'd0) begin n_errors++; $display("FAIL reset_pc_next got=%0d exp=0", pc_next); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%0b exp=0", ifid_valid); end
        n_checks++; if ({ifid_instr, ifid_pc, ifid_pc_plus1} !== 28'h0) begin
            n_errors++; $display("FAIL reset_ifid got=%h/%0d/%0d exp=0/0/0", ifid_instr, ifid_pc, ifid_pc_plus1); end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b1);
            n_checks++; if (pc_next !== 6'(i)) begin n_errors++; $display("FAIL stream_pc_next[%0d] got=%0d exp=%0d", i, pc_next, i); end
            if (i == 0) begin
                n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL boot_req got=%0b exp=0", imem_req); end
            end
            if (i >= 2) begin
                n_checks++;
                if (ifid_valid !== 1'b1 || ifid_pc !== 6'(i-2) || ifid_instr !== mem[i-2]) begin
                    n_errors++; $display("FAIL stream_ifid[%0d] got=%0b/%0d/%h exp=1/%0d/%h", i, ifid_valid, ifid_pc, ifid_instr, i-2, mem[i-2]); end
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 6'd62, 1'b1);
        n_checks++; if (pc_next !== 6'd62) begin n_errors++; $display("FAIL wrap_redirect got=%0d exp=62", pc_next); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (pc !== 6'd63 || pc_next !== 6'd0) begin n_errors++; $display("FAIL wrap_pc_next got=%0d->%0d exp=63->0", pc, pc_next); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 6'd63 || ifid_pc_plus1 !== 6'd0 || ifid_instr !== mem[63]) begin
            n_errors++; $display("FAIL wrap_ifid got=%0b/%0d/%0d/%h exp=1/63/0/%h", ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr, mem[63]); end
    endtask

    task automatic test_stall_hold();
        drive(1'b0, 1'b1, 6'd4, 1'b1);
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 6'd0, 1'b1);
            n_checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 6'd4 || ifid_instr !== mem[4]) begin
                n_errors++; $display("FAIL stall_ifid_hold[%0d] got=%0b/%0d exp=1/4", i, ifid_valid, ifid_pc); end
            n_checks++;
            if (pc_next !== 6'd6 || (i > 0 && (pc !== 6'd6 || imem_req !== 1'b0))) begin
                n_errors++; $display("FAIL stall_pc[%0d] got=pc%0d next%0d req%0b exp=next6", i, pc, pc_next, imem_req); end
        end
        drive(1'b0, 1'b0, 6'd0, 1'b0);
        n_checks++; if (pc !== 6'd6 || pc_next !== 6'd6) begin n_errors++; $display("FAIL stall_release_pc got=%0d/%0d exp=6/6", pc, pc_next); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 6'd5 || ifid_pc_plus1 !== 6'd6 || ifid_instr !== mem[5]) begin
            n_errors++; $display("FAIL stall_release_ifid got=%0b/%0d/%0d/%h exp=1/5/6/%h", ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr, mem[5]); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 6'd6) begin n_errors++; $display("FAIL stall_next_fetch got=%0b/%0d exp=1/6", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drain();
        drive(1'b0, 1'b1, 6'd7, 1'b1);
        drive(1'b0, 1'b0, 6'd0, 1'b0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 6'd7 || pc_next !== 6'd7) begin
            n_errors++; $display("FAIL drain_wait1 got=%0b/%0d/%0d exp=1/7/7", imem_req, imem_addr, pc_next); end
        drive(1'b0, 1'b1, 6'd20, 1'b0);
        n_checks++; if (imem_addr !== 6'd7 || pc_next !== 6'd20) begin
            n_errors++; $display("FAIL drain_redirect got=addr%0d next%0d exp=7/20", imem_addr, pc_next); end
        drive(1'b0, 1'b0, 6'd0, 1'b0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 6'd7 || pc !== 6'd20 || ifid_valid !== 1'b0) begin
            n_errors++; $display("FAIL drain_wait3 got=%0b/%0d pc%0d v%0b exp=1/7/20/0", imem_req, imem_addr, pc, ifid_valid); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (imem_addr !== 6'd7 || pc_next !== 6'd20) begin
            n_errors++; $display("FAIL drain_ready got=%0d/%0d exp=7/20", imem_addr, pc_next); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 6'd20) begin
            n_errors++; $display("FAIL drain_refetch got=v%0b %0b/%0d exp=0 1/20", ifid_valid, imem_req, imem_addr); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 6'd20 || ifid_instr !== mem[20]) begin
            n_errors++; $display("FAIL drain_target_ifid got=%0b/%0d/%h exp=1/20/%h", ifid_valid, ifid_pc, ifid_instr, mem[20]); end
    endtask

    task automatic test_redirect_stall();
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        drive(1'b1, 1'b1, 6'd33, 1'b1);
        n_checks++; if (ifid_valid !== 1'b1 || pc_next !== 6'd33) begin
            n_errors++; $display("FAIL rs_next got=v%0b next%0d exp=1/33", ifid_valid, pc_next); end
        drive(1'b1, 1'b0, 6'd0, 1'b0);
        n_checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 6'd33) begin
            n_errors++; $display("FAIL rs_flush got=v%0b %0b/%0d exp=0 1/33", ifid_valid, imem_req, imem_addr); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        drive(1'b0, 1'b0, 6'd0, 1'b0);
        n_checks++; if (ifid_valid !== 1'b1 || imem_req !== 1'b1) begin
            n_errors++; $display("FAIL ar_pre got=v%0b req%0b exp=1/1", ifid_valid, imem_req); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || pc_next !== 6'd0 || ifid_valid !== 1'b0 || ifid_pc !== 6'd0 || ifid_instr !== 16'h0 || ifid_pc_plus1 !== 6'd0) begin
            n_errors++; $display("FAIL ar_clear got=req%0b next%0d v%0b pc%0d i%h p1%0d exp=all0", imem_req, pc_next, ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus1); end
        @(posedge clock);
        #2 reset_n = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (imem_req !== 1'b0 || pc_next !== 6'd0) begin
            n_errors++; $display("FAIL ar_boot got=%0b/%0d exp=0/0", imem_req, pc_next); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 6'd0) begin
            n_errors++; $display("FAIL ar_first_fetch got=%0b/%0d exp=1/0", imem_req, imem_addr); end
        drive(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 6'd0 || ifid_instr !== mem[0]) begin
            n_errors++; $display("FAIL ar_first_ifid got=%0b/%0d exp=1/0", ifid_valid, ifid_pc); end
    endtask

    // Reference: decode must see instructions in program order starting at
    // the reset PC, restarting at each redirect target, each exactly once,
    // with the memory word for its address; memory requests never change
    // while outstanding.
    task automatic test_random();
        logic [5:0] exp_pc;
        logic [5:0] p1;
        logic       prev_pending;
        logic [5:0] prev_addr;
        int         consumed;
        logic       st, rv, rdy;
        logic [5:0] rt;
        apply_reset();
        exp_pc = 6'd0;
        prev_pending = 1'b0;
        prev_addr = 6'd0;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom % 4) == 0;
            rdy = ($urandom % 3) != 0;
            rv  = (i > 3) && (($urandom % 16) == 0);
            rt  = 6'($urandom);
            drive(st, rv, rt, rdy);
            if (prev_pending) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    n_errors++; $display("FAIL rnd_handshake[%0d] got=%0b/%0d exp=1/%0d", i, imem_req, imem_addr, prev_addr); end
            end
            prev_pending = imem_req && !imem_ready;
            prev_addr    = imem_addr;
            if (ifid_valid === 1'b1) begin
                p1 = ifid_pc + 6'd1;
                n_checks++;
                if (ifid_instr !== mem[ifid_pc] || ifid_pc_plus1 !== p1) begin
                    n_errors++; $display("FAIL rnd_entry[%0d] got=%h/%0d exp=%h/%0d", i, ifid_instr, ifid_pc_plus1, mem[ifid_pc], p1); end
                if (!st && !rv) begin
                    n_checks++;
                    if (ifid_pc !== exp_pc) begin
                        n_errors++; $display("FAIL rnd_order[%0d] got=%0d exp=%0d", i, ifid_pc, exp_pc); end
                    exp_pc = exp_pc + 6'd1;
                    consumed++;
                end
            end
            if (rv) exp_pc = rt;
        end
        n_checks++;
        if (consumed < 300) begin n_errors++; $display("FAIL rnd_progress got=%0d exp>=300", consumed); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        test_reset();
        test_stream();
        test_wrap();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_stall();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
